asteroid_spawner: RTL
=====================

// Module: asteroid_spawner
// PURPOSE
//  Upstream position source for one falling asteroid sprite in the game top level.
//  - Per video frame, advances the asteroid's top-left screen coordinate by a speed
//    that ramps with play progress.
//  - Respawns the asteroid at a pseudo-random x after a pseudo-random frame delay.
//  - Reports each asteroid that leaves the screen, for scoring.
//  - Top level draws the 37x37 sprite at (xpos, ypos) and freezes this block on collision.
// PARAMETERS
//  SEED         10'h2A5  LFSR seed; a zero value is illegal and is replaced by 10'h001
//  X_MIN        40       leftmost spawn x; xpos = X_MIN + lfsr[8:0] (max 551)
//  Y_START      0        spawn y
//  Y_LIMIT      480      y at or beyond which the asteroid has left the screen
//  DELAY_MIN    8        minimum respawn delay in frames (adds lfsr[3:0], 0..15)
//  SPEED_INIT   1        pixels/frame after reset or restart
//  SPEED_MAX    6        speed saturation value
//  LEVEL_EVERY  4        passes per speed increment
// PORTS
//  clk         in   1   25 MHz pixel clock (divided_clk domain)
//  reset       in   1   synchronous, active-low block reset
//  frame_tick  in   1   1-cycle pulse, once per frame (start of vertical blanking)
//  halt        in   1   level; high = game frozen (collide)
//  restart     in   1   1-cycle pulse; starts or restarts play
//  xpos        out  10  asteroid top-left x, screen pixels
//  ypos        out  10  asteroid top-left y, screen pixels
//  active      out  1   asteroid is on screen and must be drawn
//  passed      out  1   1-cycle pulse when the asteroid leaves the screen
//  speed       out  3   current pixels/frame
// BEHAVIOUR
//  - All outputs registered; every update appears the cycle after the causing input.
//  - Reset (reset=0 at a clk edge) values:
//    state=IDLE, xpos=0, ypos=0, active=0, passed=0, speed=SPEED_INIT,
//    pass_cnt=0, delay=0, lfsr=SEED.
//  - LFSR: 10-bit Fibonacci, polynomial x^10+x^7+1.
//    Shifts every cycle reset is high, including while halted.
//    If the LFSR ever reaches 0, it reloads SEED.
//  - passed defaults to 0 each cycle; it is high only in the single cycle described below.
//  - Priority: reset > restart > halt > frame_tick.
//  - restart (any state): state=WAIT, delay=DELAY_MIN+lfsr[3:0], active=0,
//    speed=SPEED_INIT, pass_cnt=0; xpos/ypos hold.
//  - halt=1: state, counters and outputs hold; frame_tick ignored.
//  - IDLE: wait for restart; frame_tick ignored.
//  - WAIT, on frame_tick:
//    - delay==0: xpos=X_MIN+lfsr[8:0], ypos=Y_START, active=1, go to FALL.
//    - otherwise: delay decrements.
//  - FALL, on frame_tick: compute sum = ypos + speed (11 bits, no wrap).
//    - sum < Y_LIMIT: ypos = sum[9:0].
//    - sum >= Y_LIMIT: active=0, passed=1 for one cycle, ypos holds,
//      delay=DELAY_MIN+lfsr[3:0], go to WAIT.
//      Then, if pass_cnt==LEVEL_EVERY-1: pass_cnt=0 and speed=min(speed+1, SPEED_MAX);
//      otherwise pass_cnt increments.
//  - frame_tick outside WAIT/FALL, or with halt=1: no effect.
//  - restart in the same cycle as frame_tick: restart wins; the tick is dropped.
// TESTING
//  T1 Hold reset=0 for 3 cycles, tick frame_tick:
//     -> state IDLE, xpos=ypos=0, active=0, passed=0, speed=1; ticks ignored.
//  T2 restart, then frame_tick each frame:
//     -> active rises after exactly DELAY_MIN+lfsr[3:0]+1 ticks;
//        xpos matches the bench LFSR model and lies in 40..551.
//  T3 FALL at speed 1 from ypos=0:
//     -> ypos 0..479 over 479 ticks; 480th tick gives passed=1 for one cycle and active=0.
//  T4 Run 4 passes, then 20 more passes:
//     -> speed=2 after pass 4; speed saturates at 6 and never exceeds it.
//  T5 halt=1 at ypos=100 in FALL, 10 ticks, then release:
//     -> ypos stays 100 while halted; next tick gives 101; LFSR still advanced.
//  T6 restart and frame_tick in the same cycle mid-FALL at speed 3:
//     -> state WAIT, active=0, speed=1, pass_cnt=0, ypos unchanged, passed=0.

Source files
------------

// File: rtl/asteroid_spawner.sv
// Falling-asteroid position source: per-frame y advance, LFSR-timed respawn at random x, pass pulse.
// Latency: every output is registered and updates one clk after the causing input.
// No backpressure: frame_tick/restart are fire-and-forget pulses; halt freezes all state but the LFSR.
module asteroid_spawner #(
   parameter logic [9:0] SEED        = 10'h2A5,
   parameter int         X_MIN       = 40,
   parameter int         Y_START     = 0,
   parameter int         Y_LIMIT     = 480,
   parameter int         DELAY_MIN   = 8,
   parameter int         SPEED_INIT  = 1,
   parameter int         SPEED_MAX   = 6,
   parameter int         LEVEL_EVERY = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       halt,
   input  logic       restart,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic       active,
   output logic       passed,
   output logic [2:0] speed
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_FALL = 2'd2;

   // An all-zero seed would lock the LFSR, so it is forced to 1.
   localparam logic [9:0]  SEED_OK    = (SEED == 10'd0) ? 10'h001 : SEED;
   localparam logic [9:0]  X_MIN_L    = 10'(X_MIN);
   localparam logic [9:0]  Y_START_L  = 10'(Y_START);
   localparam logic [10:0] Y_LIMIT_L  = 11'(Y_LIMIT);
   localparam logic [4:0]  DLY_MIN_L  = 5'(DELAY_MIN);
   localparam logic [2:0]  SPD_INIT_L = 3'(SPEED_INIT);
   localparam logic [2:0]  SPD_MAX_L  = 3'(SPEED_MAX);
   localparam logic [7:0]  LVL_LAST_L = 8'(LEVEL_EVERY - 1);

   logic [1:0]  state;
   logic [9:0]  lfsr;
   logic [4:0]  delay;
   logic [7:0]  pass_cnt;
   logic [9:0]  lfsr_nxt;
   logic [10:0] sum;
   logic [4:0]  new_delay;

   // Next LFSR value, next falling y (11 bits so it cannot wrap) and the respawn delay.
   always_comb begin
      lfsr_nxt  = (lfsr == 10'd0) ? SEED_OK : {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      sum       = {1'b0, ypos} + {8'd0, speed};
      new_delay = DLY_MIN_L + {1'b0, lfsr[3:0]};
   end

   // LFSR free-runs whenever out of reset, halted or not.
   always_ff @(posedge clk) begin
      if (!reset) lfsr <= SEED_OK;
      else        lfsr <= lfsr_nxt;
   end

   // Play FSM: restart beats halt, halt beats frame_tick.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_IDLE;
         xpos     <= 10'd0;
         ypos     <= 10'd0;
         active   <= 1'b0;
         passed   <= 1'b0;
         speed    <= SPD_INIT_L;
         pass_cnt <= 8'd0;
         delay    <= 5'd0;
      end else begin
         passed <= 1'b0;
         if (restart) begin
            state    <= ST_WAIT;
            delay    <= new_delay;
            active   <= 1'b0;
            speed    <= SPD_INIT_L;
            pass_cnt <= 8'd0;
         end else if (!halt && frame_tick) begin
            case (state)
               ST_WAIT: begin
                  if (delay == 5'd0) begin
                     xpos   <= X_MIN_L + {1'b0, lfsr[8:0]};
                     ypos   <= Y_START_L;
                     active <= 1'b1;
                     state  <= ST_FALL;
                  end else begin
                     delay <= delay - 5'd1;
                  end
               end
               ST_FALL: begin
                  if (sum < Y_LIMIT_L) begin
                     ypos <= sum[9:0];
                  end else begin
                     active <= 1'b0;
                     passed <= 1'b1;
                     delay  <= new_delay;
                     state  <= ST_WAIT;
                     if (pass_cnt == LVL_LAST_L) begin
                        pass_cnt <= 8'd0;
                        speed    <= (speed >= SPD_MAX_L) ? SPD_MAX_L : speed + 3'd1;
                     end else begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
